// File: rtl/pmem_arbiter.sv
// pmem_arbiter: initiator side of the 256-bit line memory protocol.
// Arbitrates icache line fills and dcache fills/writebacks onto one memory
// port, holds the request stable for the whole transaction, and recovers
// from a memory error or a hung transaction via a timeout and drain period.
//
// Handshake: a client raises read/write and holds it (with its address and
// write data) until it sees its one-cycle resp or error pulse; the memory
// sees a strobe that stays high, with frozen address/wdata, until it answers
// with pmem_resp (completion) or pmem_error (abort). Every output is a
// register; fsm_state mirrors the controller state for observation.
module pmem_arbiter #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int DRAIN_CYCLES   = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_read,
    input  logic [31:0]  i_address,
    output logic         i_resp,
    output logic         i_error,
    output logic [255:0] i_rdata,
    input  logic         d_read,
    input  logic         d_write,
    input  logic [31:0]  d_address,
    input  logic [255:0] d_wdata,
    output logic         d_resp,
    output logic         d_error,
    output logic [255:0] d_rdata,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [31:0]  pmem_address,
    output logic [255:0] pmem_wdata,
    input  logic         pmem_resp,
    input  logic         pmem_error,
    input  logic [255:0] pmem_rdata,
    output logic [1:0]   fsm_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DONE  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    state_t         state;
    state_t         state_next;
    logic [TW-1:0]  timer;
    logic [DW-1:0]  drain_cnt;
    logic           last_grant;   // 1 = dcache was granted most recently
    logic           owner_d;      // 1 = current transaction belongs to dcache
    logic           grant_valid;
    logic           grant_d;
    logic           finish_ok;
    logic           abort;
    logic           d_req;
    logic           unused_bits;

    assign d_req       = d_read | d_write;
    assign fsm_state   = state;
    // Line alignment drops the low address bits by design.
    assign unused_bits = ^{i_address[4:0], d_address[4:0]};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decision plus grant / completion / abort strobes.
    always_comb begin
        state_next  = state;
        grant_valid = 1'b0;
        grant_d     = 1'b0;
        finish_ok   = 1'b0;
        abort       = 1'b0;
        case (state)
            IDLE: begin
                if (i_read || d_req) begin
                    grant_valid = 1'b1;
                    // With both asking, serve whoever was not served last.
                    if (i_read && d_req) grant_d = ~last_grant;
                    else                 grant_d = d_req;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                // A response in the same cycle as an error still completes.
                if (pmem_resp) begin
                    finish_ok  = 1'b1;
                    state_next = DONE;
                end else if (pmem_error || (timer == TW'(TIMEOUT_CYCLES - 1))) begin
                    abort      = 1'b1;
                    state_next = DRAIN;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            DRAIN: begin
                if (drain_cnt == DW'(DRAIN_CYCLES - 1)) state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Busy timeout counter and drain counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer     <= '0;
            drain_cnt <= '0;
        end else begin
            if (grant_valid)          timer <= '0;
            else if (state == BUSY)   timer <= timer + TW'(1);
            if (state == DRAIN)       drain_cnt <= drain_cnt + DW'(1);
            else                      drain_cnt <= '0;
        end
    end

    // Memory-side request registers: loaded on grant, frozen while BUSY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_address <= '0;
            pmem_wdata   <= '0;
            owner_d      <= 1'b0;
            last_grant   <= 1'b0;
        end else if (grant_valid) begin
            owner_d    <= grant_d;
            last_grant <= grant_d;
            if (grant_d) begin
                pmem_address <= {d_address[31:5], 5'b0};
                // Read and write together is treated as a write.
                pmem_read    <= ~d_write;
                pmem_write   <= d_write;
                pmem_wdata   <= d_write ? d_wdata : '0;
            end else begin
                pmem_address <= {i_address[31:5], 5'b0};
                pmem_read    <= 1'b1;
                pmem_write   <= 1'b0;
                pmem_wdata   <= '0;
            end
        end else if (finish_ok || abort) begin
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
        end
    end

    // Client-side return: one-cycle resp/error pulses and held rdata.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_resp  <= 1'b0;
            i_error <= 1'b0;
            i_rdata <= '0;
            d_resp  <= 1'b0;
            d_error <= 1'b0;
            d_rdata <= '0;
        end else begin
            i_resp  <= 1'b0;
            i_error <= 1'b0;
            d_resp  <= 1'b0;
            d_error <= 1'b0;
            if (finish_ok) begin
                if (owner_d) begin
                    d_resp  <= 1'b1;
                    d_rdata <= pmem_rdata;
                end else begin
                    i_resp  <= 1'b1;
                    i_rdata <= pmem_rdata;
                end
            end else if (abort) begin
                if (owner_d) d_error <= 1'b1;
                else         i_error <= 1'b1;
            end
        end
    end

endmodule
